mem_stage_ob: RTL and testbench
===============================

# mem_stage_ob

Parametrised memory stage for the LoongArch pipeline, between EX and WB. It keeps up to DEPTH instructions in an in-order buffer so the data bus can have several requests outstanding. Entries match in-order `data_ok` responses and align load data. On a flush it drops every entry and silently swallows responses still owed to flushed requests. It also gives decode a forwarding lookup across all buffered entries.

## Interface
Parameters:
- DEPTH, 2: buffer entries, which is also the maximum number of outstanding data requests (≥1).
- SIDE_W, 64: opaque sideband (CSR/TLB/exception info) carried from EX to WB.

Ports:
- clk  in  1  clock
- resetn  in  1  **synchronous, active-low** reset
- flush  in  1  ertn / WB exception / TLB refetch; kills all entries
- es_to_ms_valid  in  1  EX offers an instruction
- ms_allow_in  out  1  buffer not full
- es_pc  in  32; es_gr_we  in  1; es_dest  in  5; es_res  in  32  (ALU result)
- es_mem_req  in  1  this instruction's request was accepted on the data bus
- es_ld  in  1  load (result comes from memory)
- es_ld_op  in  3  [0] byte, [1] half, [2] sign-extend; 0 means word
- es_addr_lo  in  2  address bits [1:0]
- es_ex  in  1  exception pending (es_mem_req must be 0)
- es_side  in  SIDE_W
- data_sram_data_ok  in  1; data_sram_rdata  in  32
- ms_to_ws_valid  out  1; ws_allow_in  in  1
- ms_pc  out  32; ms_gr_we  out  1; ms_dest  out  5; ms_result  out  32; ms_ex  out  1; ms_side  out  SIDE_W  (head entry)
- ms_ex_any  out  1  some valid entry has es_ex; EX uses it to suppress stores
- ds_src1, ds_src2  in  5  decode source registers
- ms_src1_hit / ms_src2_hit  out  1; ms_src1_rdy / ms_src2_rdy  out  1; ms_src1_data / ms_src2_data  out  32
- ms_resp_err  out  1  one-cycle pulse: `data_ok` arrived with nothing pending

## Operation
- Each entry holds: valid, pc, gr_we, dest, result, ld, ld_op, addr_lo, ex, side, wait (waiting for `data_ok`).
- Enqueue when es_to_ms_valid && ms_allow_in && !flush. The entry's wait bit is set to es_mem_req.
- ms_allow_in = (count < DEPTH). It does not depend on ws_allow_in.
- Responses are in order:
  - If discard > 0, `data_ok` decrements discard and is dropped.
  - Otherwise `data_ok` completes the oldest entry with wait=1: it clears wait, and for a load writes the aligned rdata into result.
  - For a store, result keeps es_res.
- Alignment:
  - byte: lane = addr_lo.
  - half: upper half when addr_lo[1]=1.
  - Sign-extend when ld_op[2]=1, zero-extend otherwise.
- Head output: ms_to_ws_valid = head valid && !head wait && !flush. Dequeue when ms_to_ws_valid && ws_allow_in.
- Flush:
  - All entries are invalidated at the clock edge.
  - discard_next = discard + (entries with wait=1) + (es_mem_req of the same-cycle offer) − data_ok, where data_ok here counts only if it would not raise ms_resp_err.
- ms_resp_err fires when data_ok=1, discard=0 and no entry has wait=1.
- Forwarding (per source): look for the youngest valid entry with gr_we, dest == src and dest ≠ 0.
  - hit = such an entry exists.
  - rdy = hit && !wait.
  - data = that entry's result, or 0 when there is no hit.

## Timing
- Reset values: every entry invalid, count=0, discard=0.
- Outputs under reset: ms_allow_in=1; ms_to_ws_valid, ms_ex_any, all hit/rdy outputs and ms_resp_err are 0; data outputs are 0.
- Non-memory instruction: enqueued at edge N, offered to WB during cycle N+1. Throughput is 1 per cycle.
- Memory instruction: `data_ok` during cycle M is registered at edge M; the entry is offered to WB from cycle M+1. There is no same-cycle bypass of rdata.
- Enqueue and dequeue in the same cycle are both honoured; count is unchanged.
- A full buffer that dequeues this cycle still shows ms_allow_in=0 this cycle.
- Reset asserted mid-operation clears discard. Outstanding bus responses are the bus's responsibility.

## Configuration
- MS_FWD_EN defined: forwarding lookup as described above.
- MS_FWD_EN undefined: hit works as above (decode stalls on it), rdy=0, data=0, and the result muxes are not synthesised.

## Structure
- Package mem_stage_pkg:
  - ld_op bit positions (LD_B, LD_H, LD_S)
  - entry struct typedef
  - discard counter width, $clog2(2*DEPTH+1)
- Sub-module ms_load_align: combinational rdata/addr_lo/ld_op → 32-bit result.
- The top level holds the circular buffer (head/tail pointers), the discard counter and the forwarding priority select.

## Test plan
- ALU stream, DEPTH=2, ws_allow_in=1: one instruction per cycle; each reaches WB exactly 1 cycle after enqueue with ms_result=es_res.
- ld.b signed, addr_lo=3, rdata=0x80FF_1234: ms_result=0xFFFF_FF80. ld.hu, addr_lo=2, same rdata: 0x0000_80FF.
- Two loads outstanding, then `data_ok` with 0x11 and 0x22 on consecutive cycles: they retire in order with results 0x11 then 0x22.
- Two loads outstanding, flush: discard=2. The next two `data_ok` pulses are swallowed, a newly enqueued load then gets the third response, and ms_resp_err stays 0.
- ws_allow_in=0 with 2 entries: ms_allow_in=0 and no enqueue occurs. A spurious `data_ok` when idle gives a one-cycle ms_resp_err pulse.
- Forwarding: two entries both writing r5, the younger a waiting load. ds_src1=5 gives hit=1, rdy=0; after `data_ok` (0xAB) the next cycle gives rdy=1, data=0xAB. ds_src1=0 gives hit=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: load-op bits, buffer entry, counter width.
// Optional forwarding data path is enabled by defining MS_FWD_EN.
package mem_stage_pkg;

  localparam int LD_B = 0;
  localparam int LD_H = 1;
  localparam int LD_S = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        ld;
    logic [2:0]  ld_op;
    logic [1:0]  addr_lo;
    logic        ex;
    logic        waiting;
  } entry_t;

  function automatic int disc_w(int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/ms_load_align.sv
// Load data alignment: picks the byte/half lane and extends to 32 bits.
module ms_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_op,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    unique case (1'b1)
      ld_op[LD_B]: result = {{24{ld_op[LD_S] & b[7]}}, b};
      ld_op[LD_H]: result = {{16{ld_op[LD_S] & h[15]}}, h};
      default:     result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ob.sv
// Memory stage with in-order outstanding-request buffer and flush discard.
// Define MS_FWD_EN to build the forwarding ready/data muxes.
module mem_stage_ob
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int SIDE_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              es_to_ms_valid,
  output logic              ms_allow_in,
  input  logic [31:0]       es_pc,
  input  logic              es_gr_we,
  input  logic [4:0]        es_dest,
  input  logic [31:0]       es_res,
  input  logic              es_mem_req,
  input  logic              es_ld,
  input  logic [2:0]        es_ld_op,
  input  logic [1:0]        es_addr_lo,
  input  logic              es_ex,
  input  logic [SIDE_W-1:0] es_side,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  output logic              ms_to_ws_valid,
  input  logic              ws_allow_in,
  output logic [31:0]       ms_pc,
  output logic              ms_gr_we,
  output logic [4:0]        ms_dest,
  output logic [31:0]       ms_result,
  output logic              ms_ex,
  output logic [SIDE_W-1:0] ms_side,
  output logic              ms_ex_any,
  input  logic [4:0]        ds_src1,
  input  logic [4:0]        ds_src2,
  output logic              ms_src1_hit,
  output logic              ms_src2_hit,
  output logic              ms_src1_rdy,
  output logic              ms_src2_rdy,
  output logic [31:0]       ms_src1_data,
  output logic [31:0]       ms_src2_data,
  output logic              ms_resp_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = disc_w(DEPTH);

  entry_t            ent  [DEPTH];
  logic [SIDE_W-1:0] side [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [DW-1:0]     discard;

  function automatic logic [PW-1:0] age_idx(logic [PW-1:0] h, int i);
    int k;
    k = int'(h) + i;
    if (k >= DEPTH) k = k - DEPTH;
    return PW'(k);
  endfunction

  function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  entry_t        hd;
  entry_t        nent;
  logic [PW-1:0] wsel;
  logic          any_wait;
  logic [DW-1:0] nwait;
  logic [DW-1:0] disc_flush;
  logic          ok_disc;
  logic          ok_done;
  logic          enq;
  logic          deq;
  logic [31:0]   ld_data;
  logic [2:0]    w_op;
  logic [1:0]    w_alo;

  assign hd = ent[head];

  // Oldest waiting entry owns the next in-order response.
  always_comb begin
    wsel      = '0;
    any_wait  = 1'b0;
    nwait     = '0;
    ms_ex_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent[age_idx(head, i)].valid && ent[age_idx(head, i)].waiting) begin
        if (!any_wait) wsel = age_idx(head, i);
        any_wait = 1'b1;
        nwait    = nwait + 1'b1;
      end
      if (ent[i].valid && ent[i].ex) ms_ex_any = 1'b1;
    end
  end

  assign ms_resp_err = data_sram_data_ok && discard == '0 && !any_wait;
  assign ok_disc     = data_sram_data_ok && discard != '0;
  assign ok_done     = data_sram_data_ok && discard == '0 && any_wait;

  assign disc_flush = discard + nwait
                    + DW'(es_to_ms_valid && es_mem_req)
                    - DW'(ok_disc || ok_done);

  assign ms_allow_in    = count < CW'(DEPTH);
  assign enq            = es_to_ms_valid && ms_allow_in && !flush;
  assign ms_to_ws_valid = hd.valid && !hd.waiting && !flush;
  assign deq            = ms_to_ws_valid && ws_allow_in;

  assign w_op  = ent[wsel].ld_op;
  assign w_alo = ent[wsel].addr_lo;

  ms_load_align u_align (
    .rdata   (data_sram_rdata),
    .addr_lo (w_alo),
    .ld_op   (w_op),
    .result  (ld_data)
  );

  always_comb begin
    nent         = '0;
    nent.valid   = 1'b1;
    nent.pc      = es_pc;
    nent.gr_we   = es_gr_we;
    nent.dest    = es_dest;
    nent.result  = es_res;
    nent.ld      = es_ld;
    nent.ld_op   = es_ld_op;
    nent.addr_lo = es_addr_lo;
    nent.ex      = es_ex;
    nent.waiting = es_mem_req;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i]  <= '0;
        side[i] <= '0;
      end
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      discard <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid   <= 1'b0;
        ent[i].waiting <= 1'b0;
      end
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      discard <= disc_flush;
    end else begin
      if (ok_disc) discard <= discard - 1'b1;
      if (ok_done) begin
        ent[wsel].waiting <= 1'b0;
        if (ent[wsel].ld) ent[wsel].result <= ld_data;
      end
      if (deq) begin
        ent[head].valid <= 1'b0;
        head <= inc(head);
      end
      if (enq) begin
        ent[tail]  <= nent;
        side[tail] <= es_side;
        tail       <= inc(tail);
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  assign ms_pc     = hd.pc;
  assign ms_gr_we  = hd.gr_we;
  assign ms_dest   = hd.dest;
  assign ms_result = hd.result;
  assign ms_ex     = hd.ex;
  assign ms_side   = side[head];

  // Later (younger) matches override earlier ones.
`ifdef MS_FWD_EN
  logic [PW-1:0] sel1;
  logic [PW-1:0] sel2;
`endif

  always_comb begin
    ms_src1_hit = 1'b0;
    ms_src2_hit = 1'b0;
`ifdef MS_FWD_EN
    sel1 = '0;
    sel2 = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (ent[age_idx(head, i)].valid && ent[age_idx(head, i)].gr_we
          && ent[age_idx(head, i)].dest == ds_src1 && ds_src1 != 5'd0) begin
        ms_src1_hit = 1'b1;
`ifdef MS_FWD_EN
        sel1 = age_idx(head, i);
`endif
      end
      if (ent[age_idx(head, i)].valid && ent[age_idx(head, i)].gr_we
          && ent[age_idx(head, i)].dest == ds_src2 && ds_src2 != 5'd0) begin
        ms_src2_hit = 1'b1;
`ifdef MS_FWD_EN
        sel2 = age_idx(head, i);
`endif
      end
    end
  end

`ifdef MS_FWD_EN
  assign ms_src1_rdy  = ms_src1_hit && !ent[sel1].waiting;
  assign ms_src2_rdy  = ms_src2_hit && !ent[sel2].waiting;
  assign ms_src1_data = ms_src1_hit ? ent[sel1].result : 32'd0;
  assign ms_src2_data = ms_src2_hit ? ent[sel2].result : 32'd0;
`else
  assign ms_src1_rdy  = 1'b0;
  assign ms_src2_rdy  = 1'b0;
  assign ms_src1_data = 32'd0;
  assign ms_src2_data = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage_ob.sv
// Directed bench for mem_stage_ob (DEPTH=2).
// Forwarding expectations follow MS_FWD_EN.
module tb_mem_stage_ob;

  logic        clk = 1'b0;
  logic        resetn, flush, es_to_ms_valid, ms_allow_in;
  logic [31:0] es_pc, es_res, data_sram_rdata;
  logic        es_gr_we, es_mem_req, es_ld, es_ex;
  logic [4:0]  es_dest, ds_src1, ds_src2;
  logic [2:0]  es_ld_op;
  logic [1:0]  es_addr_lo;
  logic [63:0] es_side, ms_side;
  logic        data_sram_data_ok, ms_to_ws_valid, ws_allow_in;
  logic [31:0] ms_pc, ms_result, ms_src1_data, ms_src2_data;
  logic        ms_gr_we, ms_ex, ms_ex_any;
  logic [4:0]  ms_dest;
  logic        ms_src1_hit, ms_src2_hit, ms_src1_rdy, ms_src2_rdy;
  logic        ms_resp_err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_stage_ob #(.DEPTH(2), .SIDE_W(64)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .es_to_ms_valid(es_to_ms_valid), .ms_allow_in(ms_allow_in),
    .es_pc(es_pc), .es_gr_we(es_gr_we), .es_dest(es_dest),
    .es_res(es_res), .es_mem_req(es_mem_req), .es_ld(es_ld),
    .es_ld_op(es_ld_op), .es_addr_lo(es_addr_lo), .es_ex(es_ex),
    .es_side(es_side), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ms_to_ws_valid(ms_to_ws_valid),
    .ws_allow_in(ws_allow_in), .ms_pc(ms_pc), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .ms_result(ms_result), .ms_ex(ms_ex),
    .ms_side(ms_side), .ms_ex_any(ms_ex_any),
    .ds_src1(ds_src1), .ds_src2(ds_src2),
    .ms_src1_hit(ms_src1_hit), .ms_src2_hit(ms_src2_hit),
    .ms_src1_rdy(ms_src1_rdy), .ms_src2_rdy(ms_src2_rdy),
    .ms_src1_data(ms_src1_data), .ms_src2_data(ms_src2_data),
    .ms_resp_err(ms_resp_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; es_to_ms_valid = 0; es_pc = 0; es_gr_we = 0;
    es_dest = 0; es_res = 0; es_mem_req = 0; es_ld = 0;
    es_ld_op = 0; es_addr_lo = 0; es_ex = 0; es_side = 0;
    data_sram_data_ok = 0; data_sram_rdata = 0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] d,
                       input logic [31:0] res, input logic mem,
                       input logic [2:0] op, input logic [1:0] alo);
    idle();
    es_to_ms_valid = 1; es_pc = pc; es_gr_we = 1; es_dest = d;
    es_res = res; es_mem_req = mem; es_ld = mem;
    es_ld_op = op; es_addr_lo = alo;
  endtask

  task automatic test_reset();
    idle(); resetn = 0; ws_allow_in = 1; ds_src1 = 5; ds_src2 = 5;
    step(); step();
    checks++;
    if (ms_allow_in !== 1'b1) $display("FAIL rst_allow got %0b want 1", ms_allow_in);
    else passes++;
    checks++;
    if ({ms_to_ws_valid, ms_ex_any, ms_resp_err} !== 3'b000)
      $display("FAIL rst_flags got %b want 000", {ms_to_ws_valid, ms_ex_any, ms_resp_err});
    else passes++;
    checks++;
    if ({ms_src1_hit, ms_src2_hit, ms_src1_rdy, ms_src2_rdy} !== 4'b0)
      $display("FAIL rst_fwd got %b want 0000", {ms_src1_hit, ms_src2_hit, ms_src1_rdy, ms_src2_rdy});
    else passes++;
    checks++;
    if ({ms_pc, ms_result, ms_src1_data} !== 96'd0)
      $display("FAIL rst_data got %h %h %h want 0", ms_pc, ms_result, ms_src1_data);
    else passes++;
    resetn = 1; ds_src1 = 0; ds_src2 = 0;
    step();
  endtask

  task automatic test_alu_stream();
    for (int i = 0; i < 3; i++) begin
      offer(32'h100 + 4 * i, 5'd1, 32'hA0 + i, 0, 0, 0);
      step();
      idle();
      #1;
      checks++;
      if (ms_to_ws_valid !== 1'b1 || ms_result !== 32'hA0 + i || ms_pc !== 32'h100 + 4 * i)
        $display("FAIL alu_%0d got v=%0b r=%h pc=%h want v=1 r=%h", i,
                 ms_to_ws_valid, ms_result, ms_pc, 32'hA0 + i);
      else passes++;
    end
    step();
    checks++;
    if (ms_to_ws_valid !== 1'b0) $display("FAIL alu_drain got %0b want 0", ms_to_ws_valid);
    else passes++;
  endtask

  task automatic test_load_align();
    logic [2:0]  ops [2];
    logic [1:0]  alos [2];
    logic [31:0] exp [2];
    ops[0] = 3'b101; alos[0] = 2'd3; exp[0] = 32'hFFFF_FF80;
    ops[1] = 3'b010; alos[1] = 2'd2; exp[1] = 32'h0000_80FF;
    for (int i = 0; i < 2; i++) begin
      offer(32'h200, 5'd3, 32'h0, 1, ops[i], alos[i]);
      step();
      idle();
      #1;
      checks++;
      if (ms_to_ws_valid !== 1'b0) $display("FAIL ld_wait_%0d got %0b want 0", i, ms_to_ws_valid);
      else passes++;
      data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_1234;
      step();
      idle();
      #1;
      checks++;
      if (ms_to_ws_valid !== 1'b1 || ms_result !== exp[i])
        $display("FAIL ld_align_%0d got v=%0b r=%h want v=1 r=%h", i, ms_to_ws_valid, ms_result, exp[i]);
      else passes++;
      step();
    end
  endtask

  task automatic test_in_order();
    offer(32'h300, 5'd2, 0, 1, 0, 0); step();
    offer(32'h304, 5'd4, 0, 1, 0, 0); step();
    idle(); #1;
    checks++;
    if (ms_allow_in !== 1'b0) $display("FAIL ord_full got %0b want 0", ms_allow_in);
    else passes++;
    data_sram_data_ok = 1; data_sram_rdata = 32'h11; step();
    data_sram_rdata = 32'h22; #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_result !== 32'h11 || ms_pc !== 32'h300)
      $display("FAIL ord_first got v=%0b r=%h want v=1 r=11", ms_to_ws_valid, ms_result);
    else passes++;
    step(); idle(); #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_result !== 32'h22 || ms_pc !== 32'h304)
      $display("FAIL ord_second got v=%0b r=%h want v=1 r=22", ms_to_ws_valid, ms_result);
    else passes++;
    step();
    checks++;
    if (ms_to_ws_valid !== 1'b0) $display("FAIL ord_empty got %0b want 0", ms_to_ws_valid);
    else passes++;
  endtask

  task automatic test_flush_discard();
    offer(32'h400, 5'd2, 0, 1, 0, 0); step();
    offer(32'h404, 5'd4, 0, 1, 0, 0); step();
    idle(); flush = 1; step();
    flush = 0; #1;
    checks++;
    if (ms_allow_in !== 1'b1 || ms_to_ws_valid !== 1'b0)
      $display("FAIL fl_cleared got a=%0b v=%0b want a=1 v=0", ms_allow_in, ms_to_ws_valid);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD; #1;
      checks++;
      if (ms_resp_err !== 1'b0) $display("FAIL fl_swallow_%0d got err=%0b want 0", i, ms_resp_err);
      else passes++;
      step();
    end
    offer(32'h408, 5'd6, 0, 1, 0, 0); step();
    idle(); data_sram_data_ok = 1; data_sram_rdata = 32'h33; #1;
    checks++;
    if (ms_resp_err !== 1'b0) $display("FAIL fl_third_err got %0b want 0", ms_resp_err);
    else passes++;
    step(); idle(); #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_result !== 32'h33)
      $display("FAIL fl_third got v=%0b r=%h want v=1 r=33", ms_to_ws_valid, ms_result);
    else passes++;
    step();
  endtask

  task automatic test_backpressure();
    ws_allow_in = 0;
    offer(32'h500, 5'd7, 32'h5, 0, 0, 0); es_ex = 1; step();
    checks++;
    if (ms_ex_any !== 1'b1 || ms_ex !== 1'b1)
      $display("FAIL bp_ex got any=%0b ex=%0b want 1 1", ms_ex_any, ms_ex);
    else passes++;
    offer(32'h504, 5'd8, 32'h6, 0, 0, 0); step();
    offer(32'h508, 5'd9, 32'h7, 0, 0, 0); #1;
    checks++;
    if (ms_allow_in !== 1'b0) $display("FAIL bp_full got %0b want 0", ms_allow_in);
    else passes++;
    step();
    idle(); ws_allow_in = 1; #1;
    checks++;
    if (ms_allow_in !== 1'b0 || ms_pc !== 32'h500)
      $display("FAIL bp_deq_full got a=%0b pc=%h want a=0 pc=500", ms_allow_in, ms_pc);
    else passes++;
    step();
    checks++;
    if (ms_pc !== 32'h504 || ms_to_ws_valid !== 1'b1 || ms_ex_any !== 1'b0)
      $display("FAIL bp_second got pc=%h v=%0b any=%0b want 504 1 0", ms_pc, ms_to_ws_valid, ms_ex_any);
    else passes++;
    step();
    checks++;
    if (ms_to_ws_valid !== 1'b0) $display("FAIL bp_no_third got %0b want 0", ms_to_ws_valid);
    else passes++;
  endtask

  task automatic test_resp_err();
    idle(); data_sram_data_ok = 1; #1;
    checks++;
    if (ms_resp_err !== 1'b1) $display("FAIL err_pulse got %0b want 1", ms_resp_err);
    else passes++;
    step(); data_sram_data_ok = 0; #1;
    checks++;
    if (ms_resp_err !== 1'b0) $display("FAIL err_clear got %0b want 0", ms_resp_err);
    else passes++;
  endtask

  task automatic test_forward();
    logic        rdy_exp;
    logic [31:0] dat_exp;
`ifdef MS_FWD_EN
    rdy_exp = 1; dat_exp = 32'hAB;
`else
    rdy_exp = 0; dat_exp = 32'h0;
`endif
    ws_allow_in = 0;
    offer(32'h600, 5'd5, 32'h55, 0, 0, 0); step();
    offer(32'h604, 5'd5, 32'h0, 1, 0, 0); step();
    idle(); ds_src1 = 5; ds_src2 = 0; #1;
    checks++;
    if (ms_src1_hit !== 1'b1 || ms_src1_rdy !== 1'b0 || ms_src2_hit !== 1'b0)
      $display("FAIL fwd_wait got h1=%0b r1=%0b h2=%0b want 1 0 0", ms_src1_hit, ms_src1_rdy, ms_src2_hit);
    else passes++;
    data_sram_data_ok = 1; data_sram_rdata = 32'hAB; step();
    idle(); #1;
    checks++;
    if (ms_src1_hit !== 1'b1 || ms_src1_rdy !== rdy_exp || ms_src1_data !== dat_exp)
      $display("FAIL fwd_ready got h=%0b r=%0b d=%h want 1 %0b %h",
               ms_src1_hit, ms_src1_rdy, ms_src1_data, rdy_exp, dat_exp);
    else passes++;
    ds_src1 = 0; ds_src2 = 5; #1;
    checks++;
    if (ms_src1_hit !== 1'b0 || ms_src1_data !== 32'h0 || ms_src2_hit !== 1'b1)
      $display("FAIL fwd_r0 got h1=%0b d1=%h h2=%0b want 0 0 1", ms_src1_hit, ms_src1_data, ms_src2_hit);
    else passes++;
    flush = 1; step();
    flush = 0; ds_src2 = 0; ws_allow_in = 1; step();
  endtask

  task automatic test_reset_discard();
    offer(32'h700, 5'd2, 0, 1, 0, 0); step();
    offer(32'h704, 5'd3, 0, 1, 0, 0); step();
    idle(); flush = 1; step();
    flush = 0; resetn = 0; step();
    resetn = 1;
    offer(32'h708, 5'd4, 0, 1, 0, 0); step();
    idle(); data_sram_data_ok = 1; data_sram_rdata = 32'h77; step();
    idle(); #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_result !== 32'h77)
      $display("FAIL rstd_load got v=%0b r=%h want v=1 r=77", ms_to_ws_valid, ms_result);
    else passes++;
    step();
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_load_align();
    test_in_order();
    test_flush_discard();
    test_backpressure();
    test_resp_err();
    test_forward();
    test_reset_discard();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
